// File: rtl/sap_ctrl_pkg.sv
// Shared constants for the SAP-class controller/sequencer: widths, opcodes,
// control-word bit positions and one-hot T-state encodings.
package sap_ctrl_pkg;

    localparam int OP_W = 4;
    localparam int CW_W = 12;

    localparam logic [OP_W-1:0] OP_LDA = 4'b0000;
    localparam logic [OP_W-1:0] OP_ADD = 4'b0001;
    localparam logic [OP_W-1:0] OP_SUB = 4'b0010;
    localparam logic [OP_W-1:0] OP_OUT = 4'b1110;
    localparam logic [OP_W-1:0] OP_HLT = 4'b1111;

    localparam int CW_CP = 11;
    localparam int CW_EP = 10;
    localparam int CW_LM = 9;
    localparam int CW_CE = 8;
    localparam int CW_LI = 7;
    localparam int CW_EI = 6;
    localparam int CW_LA = 5;
    localparam int CW_EA = 4;
    localparam int CW_SU = 3;
    localparam int CW_EU = 2;
    localparam int CW_LB = 1;
    localparam int CW_LO = 0;

    localparam logic [5:0] T1 = 6'b000001;
    localparam logic [5:0] T2 = 6'b000010;
    localparam logic [5:0] T3 = 6'b000100;
    localparam logic [5:0] T4 = 6'b001000;
    localparam logic [5:0] T5 = 6'b010000;
    localparam logic [5:0] T6 = 6'b100000;

    typedef logic [CW_W-1:0] ctrl_word_t;

endpackage

// File: rtl/ring_counter6.sv
// Six-state one-hot ring counter (T1..T6) that rotates one position per
// enabled clock and returns to T1 on asynchronous active-low reset.
module ring_counter6
    import sap_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       clr_n,
    input  logic       en,
    output logic [5:0] q
);

    logic [5:0] state_reg;
    logic [5:0] state_next;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_reg <= T1;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        if (en) begin
            state_next = {state_reg[4:0], state_reg[5]};
        end
    end

    always_comb begin
        q = state_reg;
    end

endmodule

// File: rtl/controller_sequencer.sv
// SAP-class control unit: T-state ring, opcode decode into the control word,
// and the halt latch. Define CTRL_SINGLE_STEP_EN for the manual step input.
module controller_sequencer #(
    parameter int OP_W = 4,
    parameter int CW_W = 12
) (
    input  logic            clk,
    input  logic            clr_n,
`ifdef CTRL_SINGLE_STEP_EN
    input  logic            step,
`endif
    input  logic [OP_W-1:0] opcode,
    output logic [CW_W-1:0] ctrl,
    output logic [5:0]      tstate,
    output logic            hlt
);
    import sap_ctrl_pkg::*;

    logic            adv;
    logic            ring_en;
    logic            hlt_reg;
    logic [CW_W-1:0] cw;
    logic [CW_W-1:0] cw_masked;

`ifdef CTRL_SINGLE_STEP_EN
    logic step_s1_reg;
    logic step_s2_reg;
    logic step_s3_reg;

    // Two-flop synchroniser followed by a rising-edge detector.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            step_s1_reg <= 1'b0;
            step_s2_reg <= 1'b0;
            step_s3_reg <= 1'b0;
        end else begin
            step_s1_reg <= step;
            step_s2_reg <= step_s1_reg;
            step_s3_reg <= step_s2_reg;
        end
    end

    assign adv = step_s2_reg & ~step_s3_reg;
`else
    assign adv = 1'b1;
`endif

    assign ring_en = adv & ~hlt_reg;

    ring_counter6 u_ring (
        .clk   (clk),
        .clr_n (clr_n),
        .en    (ring_en),
        .q     (tstate)
    );

    // HLT is sampled on the edge that ends T4; the ring lands on T5 and stays.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            hlt_reg <= 1'b0;
        end else if (ring_en && tstate == T4 && opcode == OP_HLT) begin
            hlt_reg <= 1'b1;
        end
    end

    assign hlt = hlt_reg;

    always_comb begin
        cw = '0;
        case (tstate)
            T1: begin
                cw[CW_EP] = 1'b1;
                cw[CW_LM] = 1'b1;
            end
            T2: cw[CW_CP] = 1'b1;
            T3: begin
                cw[CW_CE] = 1'b1;
                cw[CW_LI] = 1'b1;
            end
            T4: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw[CW_EI] = 1'b1;
                        cw[CW_LM] = 1'b1;
                    end
                    OP_OUT: begin
                        cw[CW_EA] = 1'b1;
                        cw[CW_LO] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T5: begin
                case (opcode)
                    OP_LDA: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw[CW_CE] = 1'b1;
                        cw[CW_LB] = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                case (opcode)
                    OP_ADD: begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                    end
                    OP_SUB: begin
                        cw[CW_EU] = 1'b1;
                        cw[CW_LA] = 1'b1;
                        cw[CW_SU] = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // While waiting for a step, drivers stay on but nothing may be loaded twice.
    always_comb begin
        cw_masked = cw;
        if (!adv) begin
            cw_masked[CW_CP] = 1'b0;
            cw_masked[CW_LM] = 1'b0;
            cw_masked[CW_LI] = 1'b0;
            cw_masked[CW_LA] = 1'b0;
            cw_masked[CW_LB] = 1'b0;
            cw_masked[CW_LO] = 1'b0;
        end
    end

    assign ctrl = (hlt_reg || !clr_n) ? '0 : cw_masked;

endmodule

// File: tb/tb_controller_sequencer.sv
// Scoreboard bench for controller_sequencer: randomized opcodes against an
// instruction-level reference model; covers CTRL_SINGLE_STEP_EN when defined.
module tb_controller_sequencer;

    localparam logic [11:0] B_CP = 12'h800, B_EP = 12'h400, B_LM = 12'h200,
                            B_CE = 12'h100, B_LI = 12'h080, B_EI = 12'h040,
                            B_LA = 12'h020, B_EA = 12'h010, B_SU = 12'h008,
                            B_EU = 12'h004, B_LB = 12'h002, B_LO = 12'h001;

    typedef struct {
        logic [5:0]  t;
        logic [11:0] c;
        logic        h;
    } exp_t;

    logic        clk = 1'b0;
    logic        clr_n = 1'b0;
    logic        step = 1'b0;
    logic [3:0]  opcode = 4'b0000;
    logic [11:0] ctrl;
    logic [5:0]  tstate;
    logic        hlt;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: phase within instruction (0 = T1 .. 5 = T6) and halt flag.
    int       m_t = 0;
    bit       m_hlt = 1'b0;
    bit [3:0] m_op = 4'b0000;
    int       force_op = -1;

    controller_sequencer dut (
        .clk    (clk),
        .clr_n  (clr_n),
`ifdef CTRL_SINGLE_STEP_EN
        .step   (step),
`endif
        .opcode (opcode),
        .ctrl   (ctrl),
        .tstate (tstate),
        .hlt    (hlt)
    );

    always #5 clk = ~clk;

    // Micro-program table, written instruction by instruction.
    function automatic logic [11:0] exp_ctrl(input int ph, input bit [3:0] op);
        if (ph == 0) return B_EP | B_LM;
        if (ph == 1) return B_CP;
        if (ph == 2) return B_CE | B_LI;
        case (op)
            4'b0000: return (ph == 3) ? (B_EI | B_LM) : (ph == 4) ? (B_CE | B_LA) : 12'h000;
            4'b0001: return (ph == 3) ? (B_EI | B_LM) : (ph == 4) ? (B_CE | B_LB) : (B_EU | B_LA);
            4'b0010: return (ph == 3) ? (B_EI | B_LM) : (ph == 4) ? (B_CE | B_LB) : (B_EU | B_LA | B_SU);
            4'b1110: return (ph == 3) ? (B_EA | B_LO) : 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    function automatic bit [3:0] pick_op();
        int r;
        bit [3:0] o;
        r = $urandom_range(0, 8);
        case (r)
            0: o = 4'b0000;
            1: o = 4'b0001;
            2: o = 4'b0010;
            3: o = 4'b1110;
            default: begin
                o = 4'($urandom_range(0, 15));
                if (o == 4'b1111) o = 4'b0101;
            end
        endcase
        return o;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic choose_op();
        if (force_op >= 0) begin
            m_op = 4'(force_op);
            force_op = -1;
        end else begin
            m_op = pick_op();
        end
        opcode = m_op;
    endtask

    task automatic push_exp();
        exp_t e;
        e.t = 6'b000001 << m_t;
        e.h = m_hlt;
        e.c = m_hlt ? 12'h000 : exp_ctrl(m_t, m_op);
        q.push_back(e);
        $display("cycle: op=%b phase=T%0d hlt=%0d", m_op, m_t + 1, m_hlt);
    endtask

    // One clock: advance the model across the edge, then present the next opcode.
    task automatic tick();
        @(posedge clk);
        #1;
        if (!m_hlt) begin
            if (m_t == 3 && m_op == 4'b1111) begin
                m_hlt = 1'b1;
                m_t = 4;
            end else begin
                m_t = (m_t + 1) % 6;
                if (m_t == 0) choose_op();
            end
        end
        push_exp();
    endtask

    task automatic async_reset_pulse(input string name);
        @(negedge clk);
        #1 clr_n = 1'b0;
        #1;
        check({name, "_tstate"}, 32'(tstate), 32'h01);
        check({name, "_ctrl"}, 32'(ctrl), 32'h000);
        check({name, "_hlt"}, 32'(hlt), 32'h0);
        #1 clr_n = 1'b1;
        m_t = 0;
        m_hlt = 1'b0;
        choose_op();
    endtask

    // Monitor: compares outputs against queued expectations on every falling edge.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("tstate", 32'(tstate), 32'(e.t));
            check("ctrl", 32'(ctrl), 32'(e.c));
            check("hlt", 32'(hlt), 32'(e.h));
        end
        if (clr_n) begin
            checks++;
            if (((ctrl & (B_CP | B_EP)) == (B_CP | B_EP)) ||
                ((ctrl & (B_EA | B_EU)) == (B_EA | B_EU)) ||
                ((ctrl & (B_EI | B_CE)) == (B_EI | B_CE))) begin
                errors++;
                $display("FAIL contention: ctrl=%h has conflicting drivers", ctrl);
            end
        end
    end

    initial begin
        int guard;
        #12;
        check("rst_tstate", 32'(tstate), 32'h01);
        check("rst_ctrl", 32'(ctrl), 32'h000);
        check("rst_hlt", 32'(hlt), 32'h0);
        clr_n = 1'b1;

`ifdef CTRL_SINGLE_STEP_EN
        #1;
        check("step_idle_ctrl", 32'(ctrl), 32'(B_EP));
        repeat (10) begin
            @(posedge clk);
            #1;
            check("step_hold_tstate", 32'(tstate), 32'h01);
            check("step_hold_loads", 32'(ctrl & (B_CP | B_LM | B_LI | B_LA | B_LB | B_LO)), 32'h0);
        end
        step = 1'b1;
        @(posedge clk); #1;
        check("step_lat1_tstate", 32'(tstate), 32'h01);
        @(posedge clk); #1;
        check("step_lat2_tstate", 32'(tstate), 32'h01);
        check("step_adv_ctrl", 32'(ctrl), 32'(B_EP | B_LM));
        @(posedge clk); #1;
        check("step_adv_tstate", 32'(tstate), 32'h02);
        check("step_after_ctrl", 32'(ctrl), 32'h000);
        repeat (5) begin
            @(posedge clk); #1;
            check("step_once_tstate", 32'(tstate), 32'h02);
        end
`else
        m_t = 0;
        m_hlt = 1'b0;
        choose_op();
        #1;
        check("release_ctrl", 32'(ctrl), 32'(exp_ctrl(0, m_op)));

        // Directed fetch + ADD + SUB, then NOP, then random mix.
        force_op = 1;
        guard = 0;
        while (m_op != 4'b0001 && guard < 12) begin tick(); guard++; end
        force_op = 2;
        repeat (6) tick();
        force_op = 5;
        repeat (6) tick();
        repeat (6 * 40) tick();

        // Halt: must freeze on T5 with ctrl=0 for many clocks.
        force_op = 15;
        guard = 0;
        while (m_op != 4'b1111 && guard < 12) begin tick(); guard++; end
        repeat (30) tick();
        @(negedge clk);
        check("halt_model", 32'(m_hlt), 32'h1);
        async_reset_pulse("hlt_clear");
        repeat (12) tick();

        // Abort an ADD during T5.
        force_op = 1;
        guard = 0;
        while (!(m_op == 4'b0001 && m_t == 4) && guard < 20) begin tick(); guard++; end
        check("abort_reached_T5", 32'(m_t), 32'd4);
        async_reset_pulse("abort");
        repeat (6 * 20) tick();
`endif

        guard = 0;
        while (q.size() > 0 && guard < 5) begin @(negedge clk); guard++; end
        #1;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controller_sequencer.md
Name: controller_sequencer

Overview:
- Control unit for the 8-bit SAP-class CPU.
- Sits upstream of the program counter, MAR, RAM, IR, accumulator, ALU, B and output registers, and drives all of their enables.
- A 6-state one-hot ring counter (T1..T6) steps fetch then execute.
- The execute states decode the IR opcode nibble into a 12-bit control word; HLT freezes the machine until reset.

Parameters:
- OP_W, 4, opcode width (IR upper nibble).
- CW_W, 12, control word width; fixed by the bit map below and not meant to be overridden.

Ports:
- clk  input  1  system clock, rising edge.
- clr_n  input  1  asynchronous active-low reset.
- opcode  input  OP_W  IR[7:4], valid from T4 onward.
- ctrl  output  CW_W  control word, active-high; bit map {11:CP, 10:EP, 9:LM, 8:CE, 7:LI, 6:EI, 5:LA, 4:EA, 3:SU, 2:EU, 1:LB, 0:LO}.
- tstate  output  6  one-hot T-state, bit0=T1.
- hlt  output  1  halted flag; also used to gate the external clock.

Behaviour:
- Reset (clr_n=0, asynchronous): tstate=6'b000001, hlt=0, ctrl forced to 0 while clr_n is low.
- After release, ctrl decodes from T1 on the first clock.
- Ring counter advances one state per rising clk: T1→T2→…→T6→T1. One instruction takes exactly 6 cycles.
- Control word is combinational from the registered tstate and opcode. No extra latency: downstream registers sample it on the edge that ends the state.
- Fetch (opcode ignored):
  - T1: EP, LM.
  - T2: CP. The PC increments on the edge ending T2.
  - T3: CE, LI.
- Opcodes: LDA=0000, ADD=0001, SUB=0010, OUT=1110, HLT=1111.
- Execute:
  - LDA: T4 EI,LM; T5 CE,LA; T6 none.
  - ADD: T4 EI,LM; T5 CE,LB; T6 EU,LA.
  - SUB: same as ADD with SU also asserted in T6.
  - OUT: T4 EA,LO; T5 none; T6 none.
  - HLT: T4 none. hlt sets on the edge ending T4, and the ring then holds at T5.
  - Any other opcode is a NOP: T4–T6 all zero, and the ring still cycles.
- While hlt=1: ctrl=0, tstate is frozen, opcode is ignored. Only clr_n clears it.
- Reset mid-instruction aborts immediately to T1. No partial control word persists, and the PC is cleared separately.
- CP and EP are never asserted in the same state. ctrl never drives EA together with EU, or EI together with CE (bus contention rule). The bench asserts this.

Optional Feature:
- Macro CTRL_SINGLE_STEP_EN.
- When defined:
  - Extra input step (1 bit).
  - The ring advances only on a clock where a rising edge of step has been detected. step is synchronised through two flops plus an edge-detect flop, giving 3 cycles of latency from step to advance.
  - ctrl for the current state stays asserted while the ring waits, but CP and every load enable (LM, LI, LA, LB, LO) are masked to 0 except on the advance cycle, so no double loads occur.
- When undefined: free-running, no step port.

Decomposition:
- Package sap_ctrl_pkg:
  - opcode localparams (LDA, ADD, SUB, OUT, HLT);
  - control-bit index constants (CW_CP…CW_LO);
  - T-state one-hot constants T1..T6;
  - CW_W and OP_W.
- One natural sub-module, ring_counter6: async active-low reset, enable input, one-hot output. The top holds the decode and the halt latch.

Test Plan:
- Reset then 3 clocks, opcode=xxxx → tstate 000001→000010→000100→001000; ctrl = EP|LM, CP, CE|LI on successive states.
- opcode=0001 through T4–T6 → ctrl = EI|LM, then CE|LB, then EU|LA; SU=0 throughout. With opcode=0010, SU=1 only in T6.
- opcode=1111 at T4 → hlt=1 after that edge, tstate=T5 held for 20 clocks, ctrl=0. clr_n pulse → hlt=0, tstate=T1.
- Assert clr_n=0 mid-cycle during T5 of ADD → tstate=000001 and ctrl=0 without a clock edge.
- opcode=0101 → T4–T6 ctrl=0, ring returns to T1 after 6 clocks, hlt=0.
- CTRL_SINGLE_STEP_EN with step held low for 10 clocks → tstate unchanged, CP/load enables 0. One step pulse → exactly one advance, 3 cycles later.
